// File: rtl/mdu_unit_pkg.sv
// ---------------------------------------------------------------------------
// mdu_defs : shared definitions for the multiply/divide unit.
//   - mdu_op_e    : E-stage MDU operation encoding (4 bits)
//   - is_muldiv() : op starts a multi-cycle mult/div (controller + hazard use)
//   - is_div()    : op is a division (div/divu)
//   - is_signed_op(): op treats its operands as two's complement
// ---------------------------------------------------------------------------
package mdu_defs;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam logic [31:0] INT_MIN     = 32'h8000_0000;
  localparam logic [31:0] MINUS_ONE   = 32'hFFFF_FFFF;

  // True for every op that occupies the unit for several cycles.
  function automatic logic is_muldiv(input logic [3:0] op);
    is_muldiv = (op == MDU_MULT) || (op == MDU_MULTU) ||
                (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    is_div = (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    is_signed_op = (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_unit_calc.sv
// ---------------------------------------------------------------------------
// mdu_calc : purely combinational result generator for the MDU.
//   op_i        : operation code (mdu_defs encoding)
//   a_i, b_i    : operands (rs, rt)
//   res_hi_o    : product[63:32] for mult, remainder for div, else 0
//   res_lo_o    : product[31:0]  for mult, quotient  for div, else 0
//   div_zero_o  : divisor is zero (caller must not commit a divide)
// ---------------------------------------------------------------------------
module mdu_calc
  import mdu_defs::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div_zero_o
);

  logic        signed_s;
  logic [63:0] ext_a_s;
  logic [63:0] ext_b_s;
  logic [63:0] prod_s;
  logic        neg_a_s;
  logic        neg_b_s;
  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic        ovf_s;

  // Product and sign-magnitude divide; the low 64 bits of the product of the
  // 64-bit extended operands are correct for both signed and unsigned forms.
  always_comb begin
    signed_s   = is_signed_op(op_i);
    ext_a_s    = signed_s ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
    ext_b_s    = signed_s ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
    prod_s     = ext_a_s * ext_b_s;

    neg_a_s    = signed_s & a_i[31];
    neg_b_s    = signed_s & b_i[31];
    mag_a_s    = neg_a_s ? (32'd0 - a_i) : a_i;
    mag_b_s    = neg_b_s ? (32'd0 - b_i) : b_i;
    div_zero_o = (b_i == 32'd0);
    ovf_s      = (op_i == MDU_DIV) && (a_i == INT_MIN) && (b_i == MINUS_ONE);

    // Guard the divider so a zero divisor never produces X in simulation.
    if (div_zero_o) begin
      q_mag_s = 32'd0;
      r_mag_s = 32'd0;
    end else begin
      q_mag_s = mag_a_s / mag_b_s;
      r_mag_s = mag_a_s % mag_b_s;
    end

    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quot_s = (neg_a_s ^ neg_b_s) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s  = neg_a_s ? (32'd0 - r_mag_s) : r_mag_s;

    case (op_i)
      MDU_MULT, MDU_MULTU: begin
        res_hi_o = prod_s[63:32];
        res_lo_o = prod_s[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        if (ovf_s) begin
          res_hi_o = 32'd0;
          res_lo_o = INT_MIN;
        end else begin
          res_hi_o = rem_s;
          res_lo_o = quot_s;
        end
      end
      default: begin
        res_hi_o = 32'd0;
        res_lo_o = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// ---------------------------------------------------------------------------
// mdu_unit : E-stage multiply/divide unit owning the HI/LO pair.
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   mdu_op  : operation code (mdu_defs encoding)
//   start   : one-cycle request for mult/multu/div/divu/mthi/mtlo
//   src_a   : forwarded rs value
//   src_b   : forwarded rt value
//   busy    : multi-cycle operation in progress (registered)
//   hi_out  : architectural HI (registered)
//   lo_out  : architectural LO (registered)
//   mdu_rd  : HI for MFHI, LO for MFLO, otherwise 0 (combinational)
// The result of mult/div is computed at issue and parked in pend_hi/pend_lo;
// the counter only models latency, committing on the edge where it reads 1.
// ---------------------------------------------------------------------------
module mdu_unit
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic        start,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] mdu_rd
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;

  logic [31:0]      calc_hi_s;
  logic [31:0]      calc_lo_s;
  logic             div_zero_s;
  logic             issue_s;

  mdu_calc u_calc (
    .op_i       (mdu_op),
    .a_i        (src_a),
    .b_i        (src_b),
    .res_hi_o   (calc_hi_s),
    .res_lo_o   (calc_lo_s),
    .div_zero_o (div_zero_s)
  );

  // Requests are only accepted while idle; a start during busy is dropped.
  assign issue_s = start & ~busy_q;

  // Next-state: countdown/commit while busy, otherwise decode a new request.
  always_comb begin
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;

    if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        hi_d   = pend_hi_q;
        lo_d   = pend_lo_q;
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else if (issue_s) begin
      case (mdu_op)
        MDU_MULT, MDU_MULTU: begin
          pend_hi_d = calc_hi_s;
          pend_lo_d = calc_lo_s;
          cnt_d     = CNT_W'(MULT_CYCLES);
          busy_d    = 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          // Divide by zero leaves every piece of state untouched.
          if (!div_zero_s) begin
            pend_hi_d = calc_hi_s;
            pend_lo_d = calc_lo_s;
            cnt_d     = CNT_W'(DIV_CYCLES);
            busy_d    = 1'b1;
          end else begin
            busy_d    = 1'b0;
          end
        end
        MDU_MTHI: hi_d = src_a;
        MDU_MTLO: lo_d = src_a;
        default:  busy_d = 1'b0;
      endcase
    end else begin
      busy_d = 1'b0;
    end
  end

  // State registers; reset also aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  // Read path for mfhi/mflo straight from the architectural registers.
  always_comb begin
    case (mdu_op)
      MDU_MFHI: mdu_rd = hi_q;
      MDU_MFLO: mdu_rd = lo_q;
      default:  mdu_rd = 32'd0;
    endcase
  end

  assign busy   = busy_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage, alongside the ALU; owns the HI/LO register pair.
- Executes mult, multu, div, divu, mthi, mtlo and supplies the mfhi/mflo read value back into the E-stage result path.
- Multi-cycle; `busy` tells the hazard unit when to hold any MDU instruction in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (reset==0 clears state)
- mdu_op  in  4  operation code from E-stage decode (package encoding)
- start  in  1  one-cycle request for mult/multu/div/divu/mthi/mtlo
- src_a  in  32  forwarded rs value (SrcA_E)
- src_b  in  32  forwarded rt value (WriteData_E)
- busy  out  1  multi-cycle operation in progress
- hi_out  out  32  architectural HI
- lo_out  out  32  architectural LO
- mdu_rd  out  32  read data: HI if mdu_op==MFHI, LO if MFLO, else 0

Behaviour:
- Reset (reset==0, asynchronous): hi=0, lo=0, busy=0, counter=0, pending registers=0. Reset asserted mid-operation aborts it; HI/LO keep their reset values.
- Issue condition: start=1, busy=0, sampled on the rising edge.
- MULT/MULTU issue:
  - Compute the 64-bit product of src_a and src_b ({hi,lo}); MULT is signed, MULTU unsigned.
  - Store it in pend_hi/pend_lo at the issue edge.
  - Load counter with MULT_CYCLES; busy=1 from the next cycle.
- DIV/DIVU issue:
  - LO=quotient, HI=remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
  - src_b==0: no state change at all (HI/LO unchanged, busy stays 0).
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Otherwise load counter with DIV_CYCLES; busy=1 from the next cycle.
- Countdown, on each edge with busy=1:
  - Counter decrements.
  - On the edge where counter==1: hi<=pend_hi, lo<=pend_lo, busy<=0.
  - busy is high for exactly the configured number of cycles. The new HI/LO are visible in the first cycle with busy=0.
- MTHI/MTLO with start and !busy: hi (resp. lo) <= src_a at that edge. Single cycle; busy is not raised.
- Start while busy=1: ignored; no effect on counter, pending registers or HI/LO. The D-stage stall must prevent this.
- start with mdu_op NONE/MFHI/MFLO: no state change.
- mdu_rd is combinational from the current hi/lo registers. mfhi in the same cycle that busy falls returns the new value.
- Hazard contract for the top level: stall D when the D instruction is any MDU op and (busy | (start & op_is_muldiv)).
- Arithmetic rules:
  - Products are formed with 64-bit sign/zero extension of the operands.
  - All divide outputs are 32-bit.
  - The counter is wide enough for max(MULT_CYCLES, DIV_CYCLES).

Decomposition:
- Shared package (mdu_defs):
  - mdu_op encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - An is_muldiv helper constant/function, reused by the controller and hazard logic.
- Sub-module mdu_calc: purely combinational 64-bit result generation (product and quotient/remainder, including the overflow case). mdu_unit keeps the counter, busy, pending registers and HI/LO.

Test Plan:
- MULT src_a=0xFFFFFFFF, src_b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV by src_b=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> busy stays 0, hi/lo unchanged; mdu_op=MFHI -> mdu_rd=0x11, MFLO -> 0x22.
- MULT 3*4 issued, then start with MTHI src_a=0xAAAA while busy -> ignored; final hi=0, lo=12.
- reset pulled low at cycle 2 of a DIV -> busy, hi, lo immediately 0; after release, MFLO -> mdu_rd=0.
- Back-to-back: MULT 2*3 completes, MULT issued in the first cycle busy=0 -> second result committed exactly MULT_CYCLES later, with no lost or duplicated cycle.
